// File: rtl/nn_layer_sequencer.sv
// Run-time sequencer for the dense-layer MAC datapath: holds a writable shape table
// and walks every (layer, node, input) step over a valid/ready handshake.
module nn_layer_sequencer #(
  parameter int LAYER_WIDTH = 3,
  parameter int NODE_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_we,
  input  logic [LAYER_WIDTH-1:0] cfg_addr,
  input  logic [NODE_WIDTH-1:0]  cfg_data,
  input  logic                   start,
  input  logic                   step_ready,
  output logic                   step_valid,
  output logic [ADDR_WIDTH-1:0]  weight_addr,
  output logic [NODE_WIDTH-1:0]  in_idx,
  output logic [NODE_WIDTH-1:0]  node_idx,
  output logic [LAYER_WIDTH-1:0] layer,
  output logic                   mem_select,
  output logic                   acc_clear,
  output logic                   acc_last,
  output logic                   busy,
  output logic                   done
);

  localparam int DEPTH = 2**LAYER_WIDTH;
  localparam logic [LAYER_WIDTH-1:0] LAST_LAYER = LAYER_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_RUN, S_DONE} state_t;

  state_t                 r_state;
  logic [NODE_WIDTH-1:0]  r_shape [DEPTH];
  logic [LAYER_WIDTH-1:0] r_layer;
  logic [NODE_WIDTH-1:0]  r_node_idx;
  logic [NODE_WIDTH-1:0]  r_in_idx;
  logic [ADDR_WIDTH-1:0]  r_weight_addr;
  logic                   r_step_valid;
  logic                   r_acc_clear;
  logic                   r_acc_last;
  logic                   r_busy;
  logic                   r_done;

  logic [LAYER_WIDTH-1:0] w_layer_p1;
  logic [LAYER_WIDTH-1:0] w_layer_p2;
  logic [NODE_WIDTH-1:0]  w_in_w;
  logic [NODE_WIDTH-1:0]  w_out_w;
  logic [NODE_WIDTH-1:0]  w_in_next;
  logic                   w_in_last;
  logic                   w_node_last;
  logic                   w_in_one;
  logic                   w_cur_ok;
  logic                   w_next_ok;

  assign w_layer_p1  = r_layer + LAYER_WIDTH'(1);
  assign w_layer_p2  = r_layer + LAYER_WIDTH'(2);
  assign w_in_w      = r_shape[r_layer];
  assign w_out_w     = r_shape[w_layer_p1];
  assign w_in_next   = r_in_idx + NODE_WIDTH'(1);
  assign w_in_last   = (r_in_idx == w_in_w - NODE_WIDTH'(1));
  assign w_node_last = (r_node_idx == w_out_w - NODE_WIDTH'(1));
  assign w_in_one    = (w_in_w == NODE_WIDTH'(1));

  // A layer runs only if both its input and output widths are non-zero; the
  // look-ahead lets the final layer go straight to DONE without a CHECK bubble.
  assign w_cur_ok  = (r_layer != LAST_LAYER) && (w_in_w != '0) && (w_out_w != '0);
  assign w_next_ok = (w_layer_p1 != LAST_LAYER) && (r_shape[w_layer_p1] != '0) &&
                     (r_shape[w_layer_p2] != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      // NOTE: the shape table is deliberately reset; a cleared table is part of
      // the visible reset state, so it cannot be left to a RAM macro.
      for (int i = 0; i < DEPTH; i++) r_shape[i] <= '0;
      r_layer       <= '0;
      r_node_idx    <= '0;
      r_in_idx      <= '0;
      r_weight_addr <= '0;
      r_step_valid  <= 1'b0;
      r_acc_clear   <= 1'b0;
      r_acc_last    <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      // NOTE: every state register uses <= so all updates see pre-edge values.
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (cfg_we) r_shape[cfg_addr] <= cfg_data;
          if (start) begin
            r_state       <= S_CHECK;
            r_busy        <= 1'b1;
            r_layer       <= '0;
            r_node_idx    <= '0;
            r_in_idx      <= '0;
            r_weight_addr <= '0;
          end
        end
        S_CHECK: begin
          if (w_cur_ok) begin
            r_state      <= S_RUN;
            r_step_valid <= 1'b1;
            r_acc_clear  <= 1'b1;
            r_acc_last   <= w_in_one;
          end else begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_RUN: begin
          if (step_ready) begin
            r_weight_addr <= r_weight_addr + ADDR_WIDTH'(1);
            if (!w_in_last) begin
              r_in_idx    <= w_in_next;
              r_acc_clear <= 1'b0;
              r_acc_last  <= (w_in_next == w_in_w - NODE_WIDTH'(1));
            end else begin
              r_in_idx <= '0;
              if (!w_node_last) begin
                r_node_idx  <= r_node_idx + NODE_WIDTH'(1);
                r_acc_clear <= 1'b1;
                r_acc_last  <= w_in_one;
              end else begin
                r_node_idx   <= '0;
                r_layer      <= w_layer_p1;
                r_step_valid <= 1'b0;
                r_acc_clear  <= 1'b0;
                r_acc_last   <= 1'b0;
                if (w_next_ok) begin
                  r_state <= S_CHECK;
                end else begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                end
              end
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign step_valid  = r_step_valid;
  assign weight_addr = r_weight_addr;
  assign in_idx      = r_in_idx;
  assign node_idx    = r_node_idx;
  assign layer       = r_layer;
  assign mem_select  = r_layer[0];
  assign acc_clear   = r_acc_clear;
  assign acc_last    = r_acc_last;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Directed bench for nn_layer_sequencer: table of whole-run cases checked cycle by
// cycle against a step model, plus hand sequences for reset and table clearing.
module tb_nn_layer_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [7:0]  cfg_data;
  logic        start;
  logic        step_ready;
  logic        step_valid;
  logic [15:0] weight_addr;
  logic [7:0]  in_idx;
  logic [7:0]  node_idx;
  logic [2:0]  layer;
  logic        mem_select;
  logic        acc_clear;
  logic        acc_last;
  logic        busy;
  logic        done;

  int n_pass  = 0;
  int n_total = 0;

  nn_layer_sequencer #(.LAYER_WIDTH(3), .NODE_WIDTH(8), .ADDR_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .start(start), .step_ready(step_ready), .step_valid(step_valid),
    .weight_addr(weight_addr), .in_idx(in_idx), .node_idx(node_idx), .layer(layer),
    .mem_select(mem_select), .acc_clear(acc_clear), .acc_last(acc_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  in_i;
    logic [7:0]  node;
    logic [2:0]  lyr;
    logic        clr;
    logic        last;
  } step_t;

  typedef struct {
    logic [7:0][7:0] shape;      // network the run should execute
    bit              reload;     // write the table before starting
    bit              stall;      // step_ready pattern 1,0,0 over valid cycles
    bit              interfere;  // cfg_we shape[1]=9 and start while busy
    bit              same_cyc;   // shape[1] written in the start cycle
    int              exp_steps;
    int              exp_layers;
    int              exp_done;   // cycles from start to the done pulse
  } case_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [7:0][7:0] shp(input int a, b, c, d, e, f, g, h);
    logic [7:0][7:0] s;
    s[0] = 8'(a); s[1] = 8'(b); s[2] = 8'(c); s[3] = 8'(d);
    s[4] = 8'(e); s[5] = 8'(f); s[6] = 8'(g); s[7] = 8'(h);
    return s;
  endfunction

  task automatic load_shape(input logic [7:0][7:0] s);
    for (int i = 0; i < 8; i++) begin
      cfg_we = 1'b1; cfg_addr = 3'(i); cfg_data = s[i];
      @(negedge clk);
    end
    cfg_we = 1'b0;
  endtask

  task automatic run_case(input int id, input case_t c);
    step_t           q[$];
    step_t           e;
    logic [7:0][7:0] pre;
    int              addr, qi, k;
    bit              acc;
    string           tag;
    tag  = $sformatf("c%0d", id);
    addr = 0;
    for (int l = 0; l < 7 && c.shape[l] != 0 && c.shape[l+1] != 0; l++)
      for (int n = 0; n < int'(c.shape[l+1]); n++)
        for (int i = 0; i < int'(c.shape[l]); i++) begin
          e.addr = 16'(addr); e.in_i = 8'(i); e.node = 8'(n); e.lyr = 3'(l);
          e.clr  = (i == 0); e.last = (i == int'(c.shape[l]) - 1);
          q.push_back(e);
          addr++;
        end
    pre = c.shape;
    if (c.same_cyc) pre[1] = 8'd0;
    if (c.reload) load_shape(pre);
    start = 1'b1; step_ready = 1'b0;
    if (c.same_cyc) begin cfg_we = 1'b1; cfg_addr = 3'd1; cfg_data = c.shape[1]; end
    @(negedge clk);
    start = 1'b0; cfg_we = 1'b0;
    qi = 0; k = 0;
    for (int cyc = 1; cyc <= c.exp_done + 1; cyc++) begin
      if (c.interfere) begin
        cfg_we = (cyc == 3); cfg_addr = 3'd1; cfg_data = 8'd9; start = (cyc == 3);
      end
      if (cyc < c.exp_done) begin
        check({tag, "_busy"}, busy, 1'b1);
        check({tag, "_early_done"}, done, 1'b0);
      end else if (cyc == c.exp_done) begin
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_busy_at_done"}, busy, 1'b0);
        check({tag, "_valid_at_done"}, step_valid, 1'b0);
      end else begin
        check({tag, "_done_pulse"}, done, 1'b0);
        check({tag, "_busy_after"}, busy, 1'b0);
      end
      acc = 1'b0;
      if (step_valid) begin
        if (qi < q.size()) begin
          e = q[qi];
          check({tag, "_waddr"}, weight_addr, e.addr);
          check({tag, "_in_idx"}, in_idx, e.in_i);
          check({tag, "_node_idx"}, node_idx, e.node);
          check({tag, "_layer"}, layer, e.lyr);
          check({tag, "_mem_sel"}, mem_select, e.lyr[0]);
          check({tag, "_acc_clear"}, acc_clear, e.clr);
          check({tag, "_acc_last"}, acc_last, e.last);
        end else begin
          check({tag, "_extra_step"}, qi, q.size());
        end
        step_ready = c.stall ? (k % 3 == 0) : 1'b1;
        k++;
        acc = step_ready;
      end else begin
        check({tag, "_idle_strobes"}, {acc_clear, acc_last}, 2'b00);
        step_ready = 1'b0;
      end
      @(negedge clk);
      if (acc) qi++;
    end
    cfg_we = 1'b0; start = 1'b0; step_ready = 1'b0;
    check({tag, "_accepts"}, qi, c.exp_steps);
    check({tag, "_final_layer"}, layer, c.exp_layers);
  endtask

  case_t cases[9];

  initial begin
    int acc_cnt;
    cases[0] = '{shp(2,3,0,0,0,0,0,0), 1, 0, 0, 0, 6,  1, 8};
    cases[1] = '{shp(2,3,2,0,0,0,0,0), 1, 0, 0, 0, 12, 2, 15};
    cases[2] = '{shp(2,3,0,0,0,0,0,0), 1, 1, 0, 0, 6,  1, 18};
    cases[3] = '{shp(0,5,3,0,0,0,0,0), 1, 0, 0, 0, 0,  0, 2};
    cases[4] = '{shp(4,0,0,0,0,0,0,0), 1, 0, 0, 0, 0,  0, 2};
    cases[5] = '{shp(2,3,0,0,0,0,0,0), 1, 0, 1, 0, 6,  1, 8};
    cases[6] = '{shp(2,3,0,0,0,0,0,0), 0, 0, 0, 0, 6,  1, 8};
    cases[7] = '{shp(2,3,0,0,0,0,0,0), 1, 0, 0, 1, 6,  1, 8};
    cases[8] = '{shp(1,1,1,1,1,1,1,1), 1, 0, 0, 0, 7,  7, 15};

    reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    start = 1'b0; step_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", step_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_counters", {weight_addr, in_idx, node_idx, layer}, '0);
    check("rst_strobes", {mem_select, acc_clear, acc_last}, 3'b000);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      run_case(i, cases[i]);
      repeat (2) @(negedge clk);
    end

    // Abort an all-ones run after three accepted steps.
    load_shape(shp(1,1,1,1,1,1,1,1));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; step_ready = 1'b1; acc_cnt = 0;
    for (int cyc = 0; cyc < 20 && acc_cnt < 3; cyc++) begin
      if (step_valid) acc_cnt++;
      @(negedge clk);
    end
    check("rst_mid_reached", acc_cnt, 3);
    check("rst_mid_busy_before", busy, 1'b1);
    reset = 1'b1; step_ready = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_valid", step_valid, 1'b0);
    check("rst_mid_done", done, 1'b0);
    check("rst_mid_counters", {weight_addr, layer}, '0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_mid_no_done", done, 1'b0);
    end

    // Cleared table: a fresh start finds shape[0]==0 and runs nothing.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("clr_tbl_busy", busy, 1'b1);
    check("clr_tbl_valid1", step_valid, 1'b0);
    @(negedge clk);
    check("clr_tbl_done", done, 1'b1);
    check("clr_tbl_valid2", step_valid, 1'b0);
    @(negedge clk);
    check("clr_tbl_idle", {busy, done}, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
